song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer.sv | 177 +++++++++++++++++
 tb/tb_song_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song sequencer: fetches {dur, note, shift} words from song memory and plays
// them on a buzzer at a beat-tick rate, with pause, stop, loop and end markers.
module song_sequencer #(
  parameter int unsigned NOTE_W    = 8,
  parameter int unsigned SHIFT_W   = 2,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              pause,
  input  logic                              loop_en,
  input  logic [ADDR_W-1:0]                 song_len,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic                              mem_valid,
  input  logic [DUR_W+NOTE_W+SHIFT_W-1:0]   mem_data,
  output logic [NOTE_W-1:0]                 note_out,
  output logic [SHIFT_W-1:0]                shift_out,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned WORD_W  = DUR_W + NOTE_W + SHIFT_W;
  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned GAP_W   = $clog2(GAP_TICKS + 1);
  localparam int unsigned CNT_W   = (GAP_W > DUR_W) ? GAP_W : DUR_W;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_PLAY, ST_GAP, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, len_q, len_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    ticks_q, ticks_d;
  logic                play_q;

  logic [DUR_W-1:0]    word_dur_c;
  logic [CNT_W-1:0]    last_tick_c;
  logic                period_end_c, last_word_c, timing_c, go_next_c, go_end_c;

  assign word_dur_c   = mem_data[WORD_W-1 -: DUR_W];
  assign last_tick_c  = (state_q == ST_GAP) ? GAP_LAST : CNT_W'(dur_q) - CNT_W'(1);
  assign period_end_c = (presc_q == PRESC_MAX) && (ticks_q == last_tick_c);
  assign last_word_c  = (addr_q == len_q - ADDR_W'(1));
  assign timing_c     = ((state_q == ST_PLAY) || (state_q == ST_GAP)) && !pause;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    dur_d     = dur_q;
    note_d    = note_q;
    shift_d   = shift_q;
    presc_d   = presc_q;
    ticks_d   = ticks_q;
    go_next_c = 1'b0;
    go_end_c  = 1'b0;

    // Beat timing: prescaler rolls over into the tick counter; frozen while paused.
    if (timing_c && !period_end_c) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        ticks_d = ticks_q + CNT_W'(1);
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          addr_d  = '0;
          len_d   = song_len;
          state_d = (song_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          dur_d   = word_dur_c;
          note_d  = mem_data[SHIFT_W +: NOTE_W];
          shift_d = mem_data[SHIFT_W-1:0];
          if (word_dur_c != '0) begin
            state_d = ST_PLAY;
            presc_d = '0;
            ticks_d = '0;
          end else begin
            go_end_c = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (timing_c && period_end_c) begin
          if (GAP_TICKS != 0) begin
            state_d = ST_GAP;
            presc_d = '0;
            ticks_d = '0;
          end else begin
            go_next_c = 1'b1;
          end
        end
      end
      ST_GAP:  if (timing_c && period_end_c) go_next_c = 1'b1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (go_next_c) begin
      if (last_word_c) begin
        go_end_c = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
    end

    // End of song: either rewind for another pass or finish.
    if (go_end_c) begin
      if (loop_en) begin
        addr_d  = '0;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DONE;
      end
    end

    if (stop) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      dur_q     <= '0;
      note_q    <= '0;
      shift_q   <= '0;
      presc_q   <= '0;
      ticks_q   <= '0;
      play_q    <= 1'b0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_out <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      dur_q     <= dur_d;
      note_q    <= note_d;
      shift_q   <= shift_d;
      presc_q   <= presc_d;
      ticks_q   <= ticks_d;
      play_q    <= (state_d == ST_PLAY);
      mem_rd_en <= (state_d == ST_FETCH);
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      shift_out <= (state_d == ST_PLAY) ? shift_d : '0;
    end
  end

  assign mem_addr = addr_q;
  // Pause silences the buzzer in the very cycle it is asserted.
  assign note_out = (play_q && !pause) ? note_q : '0;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: procedural song model compared every cycle, directed
// scenarios pinned by hand-computed counts, then randomized control traffic.
module tb_song_sequencer;
  localparam int unsigned NOTE_W = 8, SHIFT_W = 2, DUR_W = 4, ADDR_W = 8;
  localparam int unsigned TICK_DIV = 4, GAP_TICKS = 1;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, loop_en, mem_valid, mem_rd_en, busy, done;
  logic [7:0]  song_len, mem_addr, note_out;
  logic [13:0] mem_data;
  logic [1:0]  shift_out;

  always #5 clk = ~clk;

  song_sequencer #(.NOTE_W(NOTE_W), .SHIFT_W(SHIFT_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
                   .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_len(song_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .note_out(note_out), .shift_out(shift_out), .busy(busy), .done(done));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Song memory with programmable latency and optional stray valid pulses.
  logic [13:0] mem_words [256];
  int          lat_min = 2, lat_max = 2, mcnt = 0;
  bit          stray_en = 0;
  logic [7:0]  maddr = 8'd0;
  initial begin
    mem_valid = 1'b0;
    mem_data  = 14'd0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_data  = 14'($urandom);
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_words[maddr];
        end
      end else if (stray_en && $urandom_range(0, 9) == 0) begin
        mem_valid = 1'b1;
      end
      if (mem_rd_en === 1'b1) begin
        maddr = mem_addr;
        mcnt  = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // Behavioural model: walks the song word by word, counting unpaused cycles.
  bit         m_busy = 0, m_rd = 0, m_done = 0, m_play = 0, m_achk = 0, ab = 0, s_loop = 0;
  logic [7:0] m_note = 8'd0, m_addr = 8'd0;
  logic [1:0] m_shift = 2'd0;

  task automatic m_set(input bit b, input bit rd, input bit dn, input bit pl, input bit ac);
    m_busy = b; m_rd = rd; m_done = dn; m_play = pl; m_achk = ac;
  endtask

  task automatic m_edge();
    @(posedge clk);
    ab     = (rst === 1'b1) || (stop === 1'b1);
    s_loop = (loop_en === 1'b1);
  endtask

  task automatic m_count(input int unsigned cycles);
    int unsigned left = cycles;
    while (left > 0) begin
      m_edge();
      if (ab) return;
      if (pause !== 1'b1) left--;
    end
  endtask

  task automatic m_song(input logic [7:0] len);
    logic [7:0]  addr = 8'd0;
    logic [13:0] w;
    int          waited;
    bit          fin = 0, at_end;
    while (!fin) begin
      m_addr = addr;
      m_set(1, 1, 0, 0, 1);
      m_edge();
      if (ab) return;
      m_set(1, 0, 0, 0, 1);
      waited = 0;
      do begin
        m_edge();
        if (ab) return;
        waited++;
      end while (mem_valid !== 1'b1 && waited < 64);
      if (mem_valid !== 1'b1) begin
        chk("mem_valid_within_bound", 32'(mem_valid), 32'(1));
        return;
      end
      w = mem_data;
      at_end = 0;
      if (w[13:10] == 4'd0) begin
        at_end = 1;
      end else begin
        m_note  = w[9:2];
        m_shift = w[1:0];
        m_set(1, 0, 0, 1, 0);
        m_count(32'(w[13:10]) * TICK_DIV);
        if (ab) return;
        if (GAP_TICKS != 0) begin
          m_set(1, 0, 0, 0, 0);
          m_count(GAP_TICKS * TICK_DIV);
          if (ab) return;
        end
        at_end = (addr == 8'(len - 8'd1));
        if (!at_end) addr = addr + 8'd1;
      end
      if (at_end) begin
        if (s_loop) addr = 8'd0;
        else fin = 1;
      end
    end
    m_set(1, 0, 1, 0, 0);
    m_edge();
  endtask

  initial begin
    forever begin
      m_set(0, 0, 0, 0, 0);
      m_edge();
      if (!ab && start === 1'b1) begin
        if (song_len == 8'd0) begin
          m_set(1, 0, 1, 0, 0);
          m_edge();
        end else begin
          m_song(song_len);
        end
      end
    end
  end

  // Per-cycle compare plus event counters used by the directed checks.
  int mon [9];
  int base [9];
  initial begin
    for (int i = 0; i < 9; i++) mon[i] = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(m_rd));
      chk("done", 32'(done), 32'(m_done));
      chk("note_out", 32'(note_out), 32'((m_play && pause !== 1'b1) ? m_note : 8'd0));
      chk("shift_out", 32'(shift_out), 32'(m_play ? m_shift : 2'd0));
      if (m_achk) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (busy === 1'b1) mon[0]++;
      if (done === 1'b1) mon[1]++;
      if (mem_rd_en === 1'b1) begin
        mon[2]++;
        if (mem_addr == 8'd0) mon[3]++;
        if (mem_addr == 8'd1) mon[4]++;
        if (mem_addr == 8'd2) mon[5]++;
      end
      if (note_out == 8'h21) mon[6]++;
      if (note_out == 8'h30) mon[7]++;
      if (note_out != 8'h00) mon[8]++;
    end
  end

  task automatic snap();
    for (int i = 0; i < 9; i++) base[i] = mon[i];
  endtask
  function automatic int dm(input int i);
    return mon[i] - base[i];
  endfunction

  task automatic go(input logic [7:0] len);
    @(negedge clk);
    song_len = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!(busy === 1'b0 && mcnt == 0) && k < bound);
    if (busy !== 1'b0) chk("idle_within_bound", 32'(busy), 32'(0));
  endtask

  task automatic wait_note(input logic [7:0] v);
    int k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (note_out !== v && k < 100);
    if (note_out !== v) chk("note_seen", 32'(note_out), 32'(v));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; song_len = 8'd0;
    for (int i = 0; i < 256; i++) mem_words[i] = 14'd0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_note_out", 32'(note_out), 32'(0));
    chk("rst_shift_out", 32'(shift_out), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;

    mem_words[0] = {4'd3, 8'h21, 2'd1};
    mem_words[1] = {4'd1, 8'h30, 2'd0};

    // Basic two-note song.
    snap(); go(8'd2); wait_idle(200);
    chk("basic_note21_cycles", 32'(dm(6)), 32'(12));
    chk("basic_note30_cycles", 32'(dm(7)), 32'(4));
    chk("basic_done_pulses", 32'(dm(1)), 32'(1));
    chk("basic_busy_cycles", 32'(dm(0)), 32'(31));

    // Pause 7 cycles in the middle of the first note.
    snap(); go(8'd2); wait_note(8'h21);
    repeat (4) @(negedge clk);
    pause = 1'b1;
    repeat (7) @(negedge clk);
    pause = 1'b0;
    wait_idle(200);
    chk("pause_note21_cycles", 32'(dm(6)), 32'(12));
    chk("pause_busy_cycles", 32'(dm(0)), 32'(38));

    // Start pulsed during PLAY is ignored.
    snap(); go(8'd2); wait_note(8'h21);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("busy_start_note", 32'(note_out), 32'(8'h21));
    chk("busy_start_reads", 32'(dm(2)), 32'(1));
    chk("busy_start_addr", 32'(mem_addr), 32'(0));
    wait_idle(200);
    chk("busy_start_done", 32'(dm(1)), 32'(1));

    // Stop in WAIT; the late memory response must be dropped.
    snap(); go(8'd2);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    #2;
    chk("stop_busy", 32'(busy), 32'(0));
    chk("stop_note", 32'(note_out), 32'(0));
    repeat (5) @(negedge clk);
    chk("stop_note_cycles", 32'(dm(8)), 32'(0));
    chk("stop_done", 32'(dm(1)), 32'(0));

    // Reset while the second note plays.
    snap(); go(8'd2); wait_note(8'h30);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    chk("rstplay_busy", 32'(busy), 32'(0));
    chk("rstplay_rd", 32'(mem_rd_en), 32'(0));
    chk("rstplay_addr", 32'(mem_addr), 32'(0));
    chk("rstplay_note", 32'(note_out), 32'(0));
    chk("rstplay_shift", 32'(shift_out), 32'(0));
    chk("rstplay_done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstplay_no_done", 32'(dm(1)), 32'(0));

    // Looping song: four passes start without a done pulse.
    snap(); loop_en = 1'b1; go(8'd2);
    for (int k = 0; k < 300 && dm(3) < 4; k++) @(negedge clk);
    chk("loop_addr0_reads", 32'(dm(3)), 32'(4));
    chk("loop_addr1_reads", 32'(dm(4)), 32'(3));
    chk("loop_no_done", 32'(dm(1)), 32'(0));
    loop_en = 1'b0;
    wait_idle(200);
    chk("loop_final_done", 32'(dm(1)), 32'(1));

    // End-of-song marker at address 1 in a five-word song.
    mem_words[0] = {4'd2, 8'h11, 2'd3};
    mem_words[1] = {4'd0, 8'h55, 2'd0};
    mem_words[2] = {4'd1, 8'h77, 2'd2};
    snap(); go(8'd5); wait_idle(200);
    chk("marker_reads", 32'(dm(2)), 32'(2));
    chk("marker_addr2_reads", 32'(dm(5)), 32'(0));
    chk("marker_note_cycles", 32'(dm(8)), 32'(8));
    chk("marker_done", 32'(dm(1)), 32'(1));

    // Empty song: done on the cycle after start, no memory reads.
    snap();
    @(negedge clk); song_len = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #2;
    chk("empty_done_2nd", 32'(done), 32'(1));
    @(negedge clk); #2;
    chk("empty_done_cleared", 32'(done), 32'(0));
    chk("empty_idle", 32'(busy), 32'(0));
    chk("empty_reads", 32'(dm(2)), 32'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++)
      mem_words[i] = {4'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3)),
                      8'($urandom_range(1, 255)), 2'($urandom)};
    lat_min = 1; lat_max = 3; stray_en = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 699) == 0);
      stop     = ($urandom_range(0, 199) == 0);
      pause    = pause ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 3) == 0);
      song_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pause = 1'b0; loop_en = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    stray_en = 0;
    wait_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
